sha2_msg_sched: RTL
===================

SHA2_MSG_SCHED -- requirements
Module: sha2_msg_sched

Interface
REQ-001 SHALL have parameter WORD_W, 32, word width: 32 selects SHA-256 schedule, 64 selects SHA-512 schedule; other values are illegal.
REQ-002 SHALL have parameter NUM_CH, 4, number of independent message blocks interleaved word-by-word; legal range 1..8.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous abort: discard current block set and return to LOAD.
REQ-006 SHALL have port in_valid_i  input  1  input word valid.
REQ-007 SHALL have port in_ready_o  output  1  block accepts input word this cycle.
REQ-008 SHALL have port in_data_i  input  WORD_W  message word; order ch0 w0, ch1 w0, .., chN-1 w0, ch0 w1, ..
REQ-009 SHALL have port out_valid_o  output  1  schedule word valid.
REQ-010 SHALL have port out_ready_i  input  1  consumer accepts schedule word.
REQ-011 SHALL have port out_data_o  output  WORD_W  schedule word W[t].
REQ-012 SHALL have port out_ch_o  output  3  channel of out_data_o.
REQ-013 SHALL have port out_idx_o  output  7  round index t of out_data_o.
REQ-014 SHALL have port out_last_o  output  1  high with final word (t=ROUNDS-1, ch=NUM_CH-1).

Function
REQ-015 SHALL define ROUNDS = 64 for WORD_W=32, 80 for WORD_W=64.
REQ-016 SHALL hold a shift register of 16*NUM_CH words, sr[0] newest; each pushed word is W[t] of current channel, so W[t-k] of that channel sits at sr[k*NUM_CH-1].
REQ-017 SHALL compute W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], modulo 2^WORD_W.
REQ-018 SHALL use, for 32-bit: sigma0 = ROTR7^ROTR18^SHR3, sigma1 = ROTR17^ROTR19^SHR10; for 64-bit: sigma0 = ROTR1^ROTR8^SHR7, sigma1 = ROTR19^ROTR61^SHR6.
REQ-019 SHALL define advance adv = !out_valid_o || out_ready_i; no state moves when adv is low (full backpressure stall).
REQ-020 SHALL implement states LOAD and EXPAND; reset state LOAD.
REQ-021 SHALL in LOAD drive in_ready_o = adv; on in_valid_i&&in_ready_o push in_data_i into sr and into output register with current ch/t.
REQ-022 SHALL in EXPAND drive in_ready_o = 0; on adv push computed W[t] into sr and output register.
REQ-023 SHALL keep channel counter ch (0..NUM_CH-1) and round counter t; ch increments per pushed word, wraps to 0 and increments t.
REQ-024 SHALL move LOAD->EXPAND when word (t=15, ch=NUM_CH-1) is pushed; EXPAND->LOAD when word (t=ROUNDS-1, ch=NUM_CH-1) is pushed, counters to 0.
REQ-025 SHALL accept the next block set's first word in the cycle after the final EXPAND push (no idle bubble).
REQ-026 SHALL register out_data_o/ch/idx/last; output latency one cycle from push; each word presented exactly once, held stable while out_valid_o && !out_ready_i.
REQ-027 SHALL on clear_i (priority over all else) set state LOAD, counters 0, out_valid_o 0; sr contents need not be cleared.
REQ-028 SHALL not change in_ready_o behaviour based on in_valid_i (no combinational loop valid->ready).

Reset
REQ-029 SHALL on rst_ni low asynchronously set state LOAD, ch=0, t=0, out_valid_o=0, out_data_o=0, out_ch_o=0, out_idx_o=0, out_last_o=0, sr all zero.
REQ-030 SHALL abandon any partial block set on reset mid-operation; first word after release is ch0 w0.

Structure
REQ-031 SHALL place ROUNDS function, sigma rotation constants for both widths and state enum in shared package sha2_pkg.
REQ-032 SHALL use one sub-module sha2_sigma (parameter WORD_W, outputs sigma0/sigma1), reusable by the compression core.

Verification
REQ-033 SHALL test WORD_W=32, NUM_CH=1, "abc" padded block (w0=0x61626380, w15=0x00000018, rest 0) -> W16=0x61626380, W17=0x000F0000, 64 words, out_last_o at t=63.
REQ-034 SHALL test NUM_CH=4, four distinct blocks interleaved, out_ready_i=1 -> each channel's 64 words match software model, ch sequence 0,1,2,3 repeating, 256 outputs.
REQ-035 SHALL test random out_ready_i low 50% -> no lost/duplicated word, out_data_o stable during stall, in_ready_o low while stalled.
REQ-036 SHALL test WORD_W=64, NUM_CH=2, SHA-512 "abc" block -> 80 words per channel match model, out_idx_o reaches 79.
REQ-037 SHALL test back-to-back block sets -> second set's ch0 w0 accepted the cycle after first set's last push.
REQ-038 SHALL test clear_i asserted at t=30 and rst_ni pulsed at t=20 -> out_valid_o 0 next cycle, in_ready_o 1, fresh block then yields correct schedule.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: round counts, sigma rotation/shift amounts for both
// word widths, and the message-schedule state encoding.
package sha2_pkg;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_EXPAND = 1'b1
  } sched_state_e;

  localparam int MSG_WORDS = 16;

  // SHA-256 small sigmas (32-bit words)
  localparam int SHA256_S0_R0 = 7;
  localparam int SHA256_S0_R1 = 18;
  localparam int SHA256_S0_SH = 3;
  localparam int SHA256_S1_R0 = 17;
  localparam int SHA256_S1_R1 = 19;
  localparam int SHA256_S1_SH = 10;

  // SHA-512 small sigmas (64-bit words)
  localparam int SHA512_S0_R0 = 1;
  localparam int SHA512_S0_R1 = 8;
  localparam int SHA512_S0_SH = 7;
  localparam int SHA512_S1_R0 = 19;
  localparam int SHA512_S1_R1 = 61;
  localparam int SHA512_S1_SH = 6;

  function automatic int unsigned sha2_rounds(input int unsigned word_w);
    return (word_w == 64) ? 80 : 64;
  endfunction

endpackage

// File: rtl/sha2_sigma.sv
// Small sigma0/sigma1 functions of the SHA-2 message schedule, selected by
// word width; purely combinational so the compression core can share it.
module sha2_sigma
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] s0_in,
  input  logic [WORD_W-1:0] s1_in,
  output logic [WORD_W-1:0] sigma0,
  output logic [WORD_W-1:0] sigma1
);

  localparam bit W64   = (WORD_W == 64);
  localparam int S0_R0 = W64 ? SHA512_S0_R0 : SHA256_S0_R0;
  localparam int S0_R1 = W64 ? SHA512_S0_R1 : SHA256_S0_R1;
  localparam int S0_SH = W64 ? SHA512_S0_SH : SHA256_S0_SH;
  localparam int S1_R0 = W64 ? SHA512_S1_R0 : SHA256_S1_R0;
  localparam int S1_R1 = W64 ? SHA512_S1_R1 : SHA256_S1_R1;
  localparam int S1_SH = W64 ? SHA512_S1_SH : SHA256_S1_SH;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  assign sigma0 = rotr(s0_in, S0_R0) ^ rotr(s0_in, S0_R1) ^ (s0_in >> S0_SH);
  assign sigma1 = rotr(s1_in, S1_R0) ^ rotr(s1_in, S1_R1) ^ (s1_in >> S1_SH);

endmodule

// File: rtl/sha2_msg_sched.sv
// SHA-2 message schedule for NUM_CH word-interleaved blocks: loads 16 words per
// channel, then expands to ROUNDS words per channel through one output register.
module sha2_msg_sched
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NUM_CH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic [2:0]        out_ch_o,
  output logic [6:0]        out_idx_o,
  output logic              out_last_o
);

  localparam int         ROUNDS      = sha2_rounds(WORD_W);
  localparam int         DEPTH       = MSG_WORDS * NUM_CH;
  localparam logic [2:0] LAST_CH     = 3'(NUM_CH - 1);
  localparam logic [6:0] LAST_T      = 7'(ROUNDS - 1);
  localparam logic [6:0] LOAD_LAST_T = 7'(MSG_WORDS - 1);

  sched_state_e      state_q, state_d;
  logic [2:0]        ch_q;
  logic [6:0]        t_q;
  logic [WORD_W-1:0] sr_q [DEPTH];

  logic              adv;
  logic              push;
  logic              ch_wrap;
  logic              final_push;
  logic [WORD_W-1:0] sig0, sig1;
  logic [WORD_W-1:0] w_new;
  logic [WORD_W-1:0] push_data;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = (state_q == ST_LOAD) && adv;
  assign push       = (state_q == ST_LOAD) ? (in_valid_i && in_ready_o) : adv;
  assign ch_wrap    = (ch_q == LAST_CH);
  assign final_push = push && (state_q == ST_EXPAND) && ch_wrap && (t_q == LAST_T);

  // W[t-k] of the channel being pushed sits k*NUM_CH-1 slots back
  sha2_sigma #(
    .WORD_W(WORD_W)
  ) u_sigma (
    .s0_in (sr_q[15*NUM_CH-1]),
    .s1_in (sr_q[2*NUM_CH-1]),
    .sigma0(sig0),
    .sigma1(sig1)
  );

  assign w_new     = sig1 + sr_q[7*NUM_CH-1] + sig0 + sr_q[DEPTH-1];
  assign push_data = (state_q == ST_LOAD) ? in_data_i : w_new;

  always_comb begin
    state_d = state_q;
    if (push && ch_wrap) begin
      if (state_q == ST_LOAD && t_q == LOAD_LAST_T) begin
        state_d = ST_EXPAND;
      end else if (state_q == ST_EXPAND && t_q == LAST_T) begin
        state_d = ST_LOAD;
      end
    end
    if (clear_i) begin
      state_d = ST_LOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_q <= '0;
      t_q  <= '0;
    end else if (clear_i) begin
      ch_q <= '0;
      t_q  <= '0;
    end else if (push) begin
      if (ch_wrap) begin
        ch_q <= '0;
        t_q  <= final_push ? 7'd0 : t_q + 7'd1;
      end else begin
        ch_q <= ch_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else if (push && !clear_i) begin
      sr_q[0] <= push_data;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  // Output stage: one word per push, held until the consumer takes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      out_idx_o   <= '0;
      out_last_o  <= 1'b0;
    end else if (clear_i) begin
      out_valid_o <= 1'b0;
    end else if (push) begin
      out_valid_o <= 1'b1;
      out_data_o  <= push_data;
      out_ch_o    <= ch_q;
      out_idx_o   <= t_q;
      out_last_o  <= final_push;
    end else if (adv) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
